interrupt_tlx_mc: RTL and testbench
===================================

Name: interrupt_tlx_mc

Overview:
Multi-channel successor of the single-channel TLX interrupt requester. Accepts NUM_CH independent interrupt requests from action/AXI-side sources and round-robin arbitrates them onto one TLX AP command port as intrp_req. Each channel's afutag carries its channel index, so up to NUM_CH interrupts are outstanding at once. Retry, pending and backoff handling is per channel, with a bounded retry count and explicit failure reporting. Sits between the action interrupt sources and the TLX command/response arbiter.

Parameters:
NUM_CH, 4, number of interrupt channels (1..16)
CH_W, $clog2(NUM_CH) min 1, channel index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
backoff_limit  in  4  backoff select; countdown = 24'h14 << backoff_limit cycles
retry_limit  in  8  max retries per interrupt; 0 = unlimited
interrupt_enable  in  1  global issue enable
interrupt  in  NUM_CH  per-channel request level
interrupt_src  in  NUM_CH*64  channel i source/object at [64i+63:64i]
interrupt_ack  out  NUM_CH  per-channel completion, held until interrupt[i] drops
int_fail  out  NUM_CH  qualifies interrupt_ack: 1 = completed with failure
rsp_stray  out  1  one-cycle pulse on an unroutable/unexpected intrp response
tlx_cmd_valid  out  1  command valid, registered
tlx_cmd_obj  out  68  {4'd0, src}
tlx_cmd_afutag  out  16  {2'b11, zero-pad, channel index}
tlx_cmd_opcode  out  8  always 8'h58 (intrp_req)
tlx_rsp_valid  in  1  response valid
tlx_rsp_afutag  in  16  response tag
tlx_rsp_opcode  in  8  8'h0C intrp_resp, 8'h1A intrp_rdy
tlx_rsp_code  in  4  response code

Behaviour:
- Reset: all channels IDLE; all outputs 0; retry counters 0; backoff counters loaded.
- Per-channel FSM (one-hot): IDLE, NEW_INT, WAIT_FOR_RSP, INT_PENDING, INT_BACKOFF, FAIL, ACK_INT.
- IDLE: interrupt[i]=1 -> capture interrupt_src slice, clear retry count, go NEW_INT.
- NEW_INT: raises request to arbiter when interrupt_enable=1. Grant -> WAIT_FOR_RSP next cycle.
- Arbiter: combinational round-robin over requesting channels, at most one grant per cycle. Pointer advances to grant+1 (mod NUM_CH) only on grant. No backpressure: the TLX side accepts every valid.
- Command regs: the cycle after a grant, tlx_cmd_valid=1 with the granted channel's captured src and afutag = {2'b11, 14'(ch)}; otherwise valid=0. Latency is interrupt rise at t -> tlx_cmd_valid at t+2 (enable high, no contention).
- Routing: a response targets channel ch only if afutag[15:14]=2'b11, afutag[13:CH_W]=0, and ch<NUM_CH. Otherwise, if the opcode is 0C/1A, pulse rsp_stray and ignore.
- WAIT_FOR_RSP, intrp_resp codes:
  - 0000 -> ACK_INT.
  - 0010 -> retry path.
  - 0100 -> INT_PENDING.
  - 1000/1001/1011/1110 -> FAIL.
  - Other codes ignored, state held.
- INT_PENDING, intrp_rdy: code 0000 -> NEW_INT without incrementing retry; 0010 -> retry path.
- Retry path: increment retry count. If retry_limit!=0 and the new count > retry_limit -> FAIL; else -> INT_BACKOFF.
- INT_BACKOFF: counter is loaded with 24'h14<<backoff_limit while not in INT_BACKOFF and decrements each cycle in it. Reaching 0 -> NEW_INT. backoff_limit is sampled continuously until entry.
- A routed response to a channel in IDLE/NEW_INT/BACKOFF/ACK/FAIL pulses rsp_stray and is ignored.
- ACK_INT: interrupt_ack[i]=1, int_fail[i]=0. FAIL: interrupt_ack[i]=1, int_fail[i]=1. Both return to IDLE when interrupt[i]=0.
- interrupt[i] dropping in any other state is ignored; the interrupt completes and ack is then seen for one cycle.
- Simultaneous events: a response to channel A and a grant to channel B in the same cycle are both honoured. A response and a grant can never target the same channel.
- interrupt_enable low while in NEW_INT: the channel waits and the arbiter pointer does not move.
- rst mid-operation: all state cleared immediately. In-flight responses arriving after reset are stray.

Decomposition:
- Shared package interrupt_tlx_pkg: opcode/response encodes, response codes, state encodes, AFUTAG_INTRP prefix 2'b11, backoff base 24'h14.
- Sub-module interrupt_tlx_ch: one channel's FSM, src capture, retry counter and backoff counter, instantiated NUM_CH times via generate.
- Top holds the round-robin arbiter, command registers and response decode/routing.

Test Plan:
- NUM_CH=4, ch2 raises interrupt with src 64'hDEAD_BEEF, then rsp 0C/0000 tag 16'hC002 -> cmd at t+2 with obj {4'd0,src} and tag C002; ack[2] next cycle until interrupt drops; int_fail=0.
- All 4 channels raise in the same cycle -> cmds on 4 consecutive cycles with tags C000, C001, C002, C003. Re-raising all after acks gives the order continuing from the pointer.
- ch1 gets code 0010, backoff_limit=0 -> reissue 20 cycles after the backoff entry. With retry_limit=2, the third retry gives FAIL: ack[1]=1, int_fail[1]=1.
- ch0 gets code 0100, then intrp_rdy 1A/0000 tag C000 -> reissue with the same src, retry count unchanged. 1A/0010 instead -> backoff.
- Response tag 16'h4001, or tag C003 with ch3 IDLE -> rsp_stray one-cycle pulse, no state change anywhere.
- interrupt_enable=0 while 2 channels request -> no cmd. Assert rst during WAIT_FOR_RSP -> all outputs 0 in the same cycle; a later response is flagged stray.

Source files
------------

// File: rtl/interrupt_tlx_pkg.sv
// Shared encodes for the multi-channel TLX interrupt requester:
// TLX opcodes, response codes, afutag prefix, backoff base and channel states.
package interrupt_tlx_pkg;

  localparam logic [7:0]  OP_INTRP_REQ  = 8'h58;
  localparam logic [7:0]  OP_INTRP_RESP = 8'h0C;
  localparam logic [7:0]  OP_INTRP_RDY  = 8'h1A;

  localparam logic [3:0]  RC_DONE    = 4'b0000;
  localparam logic [3:0]  RC_RETRY   = 4'b0010;
  localparam logic [3:0]  RC_PENDING = 4'b0100;

  localparam logic [1:0]  AFUTAG_INTRP = 2'b11;
  localparam logic [23:0] BACKOFF_BASE = 24'h14;

  typedef enum logic [6:0] {
    ST_IDLE    = 7'b000_0001,
    ST_NEW_INT = 7'b000_0010,
    ST_WAIT    = 7'b000_0100,
    ST_PENDING = 7'b000_1000,
    ST_BACKOFF = 7'b001_0000,
    ST_FAIL    = 7'b010_0000,
    ST_ACK     = 7'b100_0000
  } ch_state_e;

  function automatic logic is_fail_code(input logic [3:0] code);
    return (code == 4'b1000) || (code == 4'b1001) ||
           (code == 4'b1011) || (code == 4'b1110);
  endfunction

endpackage

// File: rtl/interrupt_tlx_mc_if.sv
// TLX AP command/response port of the interrupt requester.
interface interrupt_tlx_mc_if;
  logic        tlx_cmd_valid;
  logic [67:0] tlx_cmd_obj;
  logic [15:0] tlx_cmd_afutag;
  logic [7:0]  tlx_cmd_opcode;
  logic        tlx_rsp_valid;
  logic [15:0] tlx_rsp_afutag;
  logic [7:0]  tlx_rsp_opcode;
  logic [3:0]  tlx_rsp_code;

  modport master (
    output tlx_cmd_valid, tlx_cmd_obj, tlx_cmd_afutag, tlx_cmd_opcode,
    input  tlx_rsp_valid, tlx_rsp_afutag, tlx_rsp_opcode, tlx_rsp_code
  );

  modport slave (
    input  tlx_cmd_valid, tlx_cmd_obj, tlx_cmd_afutag, tlx_cmd_opcode,
    output tlx_rsp_valid, tlx_rsp_afutag, tlx_rsp_opcode, tlx_rsp_code
  );
endinterface

// File: rtl/interrupt_tlx_ch.sv
// One interrupt channel: request FSM, source capture, retry and backoff counters.
//
// state      | meaning
// IDLE       | no interrupt in progress
// NEW_INT    | requesting the arbiter for a command slot
// WAIT       | intrp_req issued, waiting for intrp_resp
// PENDING    | host deferred the interrupt, waiting for intrp_rdy
// BACKOFF    | counting down before reissue
// FAIL       | completed with failure, ack held until request drops
// ACK        | completed successfully, ack held until request drops
module interrupt_tlx_ch
  import interrupt_tlx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt_enable,
  input  logic        interrupt,
  input  logic [63:0] src_in,
  input  logic [3:0]  backoff_limit,
  input  logic [7:0]  retry_limit,
  input  logic        grant,
  input  logic        rsp_hit,
  input  logic [7:0]  rsp_opcode,
  input  logic [3:0]  rsp_code,
  output logic        req,
  output logic [63:0] src_q,
  output logic        ack,
  output logic        fail,
  output logic        rsp_bad
);

  ch_state_e   state_q, state_d;
  logic [7:0]  retry_q, retry_d, retry_next;
  logic [23:0] bo_cnt_q;
  logic        retry_exceeded, rsp_resp, rsp_rdy;

  assign rsp_resp = rsp_hit && (rsp_opcode == OP_INTRP_RESP);
  assign rsp_rdy  = rsp_hit && (rsp_opcode == OP_INTRP_RDY);

  // saturate so an unlimited retry budget never wraps back to zero
  assign retry_next     = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
  assign retry_exceeded = (retry_limit != 8'd0) && (retry_next > retry_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      retry_q  <= '0;
      src_q    <= '0;
      bo_cnt_q <= BACKOFF_BASE;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      if (state_q == ST_IDLE && interrupt) src_q <= src_in;
      if (state_q != ST_BACKOFF)           bo_cnt_q <= BACKOFF_BASE << backoff_limit;
      else if (bo_cnt_q != '0)             bo_cnt_q <= bo_cnt_q - 24'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    unique case (state_q)
      ST_IDLE: begin
        if (interrupt) begin
          state_d = ST_NEW_INT;
          retry_d = '0;
        end
      end
      ST_NEW_INT: begin
        if (grant) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rsp_resp) begin
          if (rsp_code == RC_DONE)         state_d = ST_ACK;
          else if (rsp_code == RC_PENDING) state_d = ST_PENDING;
          else if (is_fail_code(rsp_code)) state_d = ST_FAIL;
          else if (rsp_code == RC_RETRY) begin
            retry_d = retry_next;
            state_d = retry_exceeded ? ST_FAIL : ST_BACKOFF;
          end
        end
      end
      ST_PENDING: begin
        if (rsp_rdy) begin
          if (rsp_code == RC_DONE) state_d = ST_NEW_INT;
          else if (rsp_code == RC_RETRY) begin
            retry_d = retry_next;
            state_d = retry_exceeded ? ST_FAIL : ST_BACKOFF;
          end
        end
      end
      ST_BACKOFF: begin
        if (bo_cnt_q <= 24'd1) state_d = ST_NEW_INT;
      end
      ST_ACK, ST_FAIL: begin
        if (!interrupt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req     = (state_q == ST_NEW_INT) && interrupt_enable;
  assign ack     = (state_q == ST_ACK) || (state_q == ST_FAIL);
  assign fail    = (state_q == ST_FAIL);
  assign rsp_bad = rsp_hit && !(((state_q == ST_WAIT) && (rsp_opcode == OP_INTRP_RESP)) ||
                                ((state_q == ST_PENDING) && (rsp_opcode == OP_INTRP_RDY)));

endmodule

// File: rtl/interrupt_tlx_mc.sv
// Multi-channel TLX interrupt requester: per-channel FSMs, round-robin
// arbiter onto one intrp_req command port, and response routing by afutag.
module interrupt_tlx_mc
  import interrupt_tlx_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           backoff_limit,
  input  logic [7:0]           retry_limit,
  input  logic                 interrupt_enable,
  input  logic [NUM_CH-1:0]    interrupt,
  input  logic [NUM_CH*64-1:0] interrupt_src,
  output logic [NUM_CH-1:0]    interrupt_ack,
  output logic [NUM_CH-1:0]    int_fail,
  output logic                 rsp_stray,
  interrupt_tlx_mc_if.master   tlx
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       req, rsp_hit, rsp_bad;
  logic [NUM_CH-1:0][63:0] ch_src;
  logic [CH_W-1:0]         ptr_q, gnt_idx, rsp_ch;
  logic                    gnt_any, rsp_intrp, tag_ok;
  int                      idx;

  assign rsp_intrp = tlx.tlx_rsp_valid &&
                     ((tlx.tlx_rsp_opcode == OP_INTRP_RESP) || (tlx.tlx_rsp_opcode == OP_INTRP_RDY));
  assign rsp_ch    = tlx.tlx_rsp_afutag[CH_W-1:0];
  assign tag_ok    = (tlx.tlx_rsp_afutag[15:14] == AFUTAG_INTRP) &&
                     (tlx.tlx_rsp_afutag[13:CH_W] == '0) &&
                     (int'(rsp_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign rsp_hit[i] = rsp_intrp && tag_ok && (int'(rsp_ch) == i);

    interrupt_tlx_ch u_ch (
      .clk              (clk),
      .rst              (rst),
      .interrupt_enable (interrupt_enable),
      .interrupt        (interrupt[i]),
      .src_in           (interrupt_src[64*i +: 64]),
      .backoff_limit    (backoff_limit),
      .retry_limit      (retry_limit),
      .grant            (gnt_any && (int'(gnt_idx) == i)),
      .rsp_hit          (rsp_hit[i]),
      .rsp_opcode       (tlx.tlx_rsp_opcode),
      .rsp_code         (tlx.tlx_rsp_code),
      .req              (req[i]),
      .src_q            (ch_src[i]),
      .ack              (interrupt_ack[i]),
      .fail             (int_fail[i]),
      .rsp_bad          (rsp_bad[i])
    );
  end

  // first requester at or after the pointer, wrapping at NUM_CH
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q              <= '0;
      tlx.tlx_cmd_valid  <= 1'b0;
      tlx.tlx_cmd_obj    <= '0;
      tlx.tlx_cmd_afutag <= '0;
      rsp_stray          <= 1'b0;
    end else begin
      tlx.tlx_cmd_valid <= gnt_any;
      if (gnt_any) begin
        tlx.tlx_cmd_obj    <= {4'd0, ch_src[gnt_idx]};
        tlx.tlx_cmd_afutag <= {AFUTAG_INTRP, 14'(gnt_idx)};
        ptr_q              <= (int'(gnt_idx) >= NUM_CH - 1) ? '0 : CH_W'(int'(gnt_idx) + 1);
      end else begin
        tlx.tlx_cmd_obj    <= '0;
        tlx.tlx_cmd_afutag <= '0;
      end
      rsp_stray <= rsp_intrp && (!tag_ok || (|rsp_bad));
    end
  end

  assign tlx.tlx_cmd_opcode = OP_INTRP_REQ;

endmodule

// File: tb/tb_interrupt_tlx_mc.sv
// Directed bench for interrupt_tlx_mc: vector table of single-interrupt
// transactions plus hand sequences for arbitration, retry, pending, stray and reset.
module tb_interrupt_tlx_mc;

  localparam int NUM_CH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           backoff_limit;
  logic [7:0]           retry_limit;
  logic                 interrupt_enable;
  logic [NUM_CH-1:0]    interrupt;
  logic [NUM_CH*64-1:0] interrupt_src;
  logic [NUM_CH-1:0]    interrupt_ack;
  logic [NUM_CH-1:0]    int_fail;
  logic                 rsp_stray;

  interrupt_tlx_mc_if tlx ();

  interrupt_tlx_mc #(.NUM_CH(NUM_CH)) dut (
    .clk              (clk),
    .rst              (rst),
    .backoff_limit    (backoff_limit),
    .retry_limit      (retry_limit),
    .interrupt_enable (interrupt_enable),
    .interrupt        (interrupt),
    .interrupt_src    (interrupt_src),
    .interrupt_ack    (interrupt_ack),
    .int_fail         (int_fail),
    .rsp_stray        (rsp_stray),
    .tlx              (tlx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          ch;
    logic [63:0] src;
    logic [15:0] tag;
    logic [7:0]  op;
    logic [3:0]  code;
    logic        exp_stray;
    logic        exp_ack;
    logic        exp_fail;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] tag_of(input int ch);
    return {2'b11, 14'(ch)};
  endfunction

  task automatic respond(input logic [15:0] tag, input logic [7:0] op, input logic [3:0] code);
    tlx.tlx_rsp_valid  = 1'b1;
    tlx.tlx_rsp_afutag = tag;
    tlx.tlx_rsp_opcode = op;
    tlx.tlx_rsp_code   = code;
    tick();
    tlx.tlx_rsp_valid  = 1'b0;
    tlx.tlx_rsp_afutag = '0;
    tlx.tlx_rsp_opcode = '0;
    tlx.tlx_rsp_code   = '0;
  endtask

  task automatic raise_and_cmd(input int ch, input logic [63:0] src);
    interrupt[ch]               = 1'b1;
    interrupt_src[64*ch +: 64]  = src;
    tick();
    chk($sformatf("lat_t1_ch%0d", ch), tlx.tlx_cmd_valid, 1'b0);
    tick();
    chk($sformatf("cmd_valid_ch%0d", ch), tlx.tlx_cmd_valid, 1'b1);
    chk($sformatf("cmd_obj_ch%0d", ch), tlx.tlx_cmd_obj, {4'd0, src});
    chk($sformatf("cmd_tag_ch%0d", ch), tlx.tlx_cmd_afutag, tag_of(ch));
  endtask

  task automatic drop(input int ch);
    interrupt[ch] = 1'b0;
    tick();
    chk($sformatf("drop_ack_ch%0d", ch), interrupt_ack, 4'h0);
    chk($sformatf("drop_fail_ch%0d", ch), int_fail, 4'h0);
  endtask

  task automatic wait_cmd(output int n);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (tlx.tlx_cmd_valid) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int               n;
    int               cnt;
    logic [NUM_CH-1:0] ev;
    int               order [4];

    rst                = 1'b1;
    backoff_limit      = 4'd0;
    retry_limit        = 8'd0;
    interrupt_enable   = 1'b1;
    interrupt          = '0;
    interrupt_src      = '0;
    tlx.tlx_rsp_valid  = 1'b0;
    tlx.tlx_rsp_afutag = '0;
    tlx.tlx_rsp_opcode = '0;
    tlx.tlx_rsp_code   = '0;

    vecs[0] = '{2, 64'h0000_0000_DEAD_BEEF, 16'hC002, 8'h0C, 4'b0000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{0, 64'h0123_4567_89AB_CDEF, 16'hC000, 8'h0C, 4'b1000, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{3, 64'hFFFF_0000_FFFF_0000, 16'hC003, 8'h0C, 4'b1001, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1, 64'h1111_2222_3333_4444, 16'hC001, 8'h0C, 4'b1011, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{2, 64'h8000_0000_0000_0001, 16'hC002, 8'h0C, 4'b1110, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1, 64'h5A5A_5A5A_5A5A_5A5A, 16'hC001, 8'h0C, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{3, 64'h0000_0000_0000_0033, 16'h4003, 8'h0C, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{0, 64'h0000_0000_0000_0077, 16'hC100, 8'h0C, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{2, 64'h0000_0000_0000_0099, 16'hC002, 8'h0D, 4'b0000, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_valid", tlx.tlx_cmd_valid, 1'b0);
    chk("rst_cmd_obj", tlx.tlx_cmd_obj, 68'h0);
    chk("rst_cmd_tag", tlx.tlx_cmd_afutag, 16'h0);
    chk("rst_ack", interrupt_ack, 4'h0);
    chk("rst_fail", int_fail, 4'h0);
    chk("rst_stray", rsp_stray, 1'b0);
    chk("cmd_opcode", tlx.tlx_cmd_opcode, 8'h58);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      raise_and_cmd(vecs[i].ch, vecs[i].src);
      respond(vecs[i].tag, vecs[i].op, vecs[i].code);
      ev = '0;
      if (vecs[i].exp_ack) ev[vecs[i].ch] = 1'b1;
      chk($sformatf("v%0d_ack", i), interrupt_ack, ev);
      ev = '0;
      if (vecs[i].exp_fail) ev[vecs[i].ch] = 1'b1;
      chk($sformatf("v%0d_fail", i), int_fail, ev);
      chk($sformatf("v%0d_stray", i), rsp_stray, vecs[i].exp_stray);
      chk($sformatf("v%0d_single_cmd", i), tlx.tlx_cmd_valid, 1'b0);
      if (!vecs[i].exp_ack) begin
        respond(tag_of(vecs[i].ch), 8'h0C, 4'b0000);
        chk($sformatf("v%0d_cleanup_ack", i), interrupt_ack[vecs[i].ch], 1'b1);
        chk($sformatf("v%0d_stray_pulse", i), rsp_stray, 1'b0);
      end
      drop(vecs[i].ch);
    end

    // round robin from a freshly reset pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int c = 0; c < NUM_CH; c++) begin
      interrupt[c]              = 1'b1;
      interrupt_src[64*c +: 64] = 64'h1000 + 64'(c);
    end
    tick();
    chk("rr_t1", tlx.tlx_cmd_valid, 1'b0);
    for (int k = 0; k < NUM_CH; k++) begin
      tick();
      chk($sformatf("rr1_valid%0d", k), tlx.tlx_cmd_valid, 1'b1);
      chk($sformatf("rr1_tag%0d", k), tlx.tlx_cmd_afutag, tag_of(k));
      chk($sformatf("rr1_obj%0d", k), tlx.tlx_cmd_obj, 68'h1000 + 68'(k));
    end
    tick();
    chk("rr1_idle", tlx.tlx_cmd_valid, 1'b0);
    for (int k = 0; k < NUM_CH; k++) respond(tag_of(k), 8'h0C, 4'b0000);
    chk("rr1_ack_all", interrupt_ack, 4'hF);
    chk("rr1_fail_none", int_fail, 4'h0);
    interrupt = '0;
    tick();
    chk("rr1_ack_clear", interrupt_ack, 4'h0);

    raise_and_cmd(1, 64'h55);
    respond(16'hC001, 8'h0C, 4'b0000);
    chk("rr_ch1_ack", interrupt_ack, 4'b0010);
    drop(1);

    order = '{2, 3, 0, 1};
    for (int c = 0; c < NUM_CH; c++) interrupt[c] = 1'b1;
    tick();
    for (int k = 0; k < NUM_CH; k++) begin
      tick();
      chk($sformatf("rr2_valid%0d", k), tlx.tlx_cmd_valid, 1'b1);
      chk($sformatf("rr2_tag%0d", k), tlx.tlx_cmd_afutag, tag_of(order[k]));
    end
    for (int k = 0; k < NUM_CH; k++) respond(tag_of(k), 8'h0C, 4'b0000);
    chk("rr2_ack_all", interrupt_ack, 4'hF);
    interrupt = '0;
    tick();

    // retry with backoff, then exhaust the retry budget
    retry_limit   = 8'd2;
    backoff_limit = 4'd0;
    raise_and_cmd(1, 64'hA5A5);
    respond(16'hC001, 8'h0C, 4'b0010);
    chk("retry1_no_ack", interrupt_ack, 4'h0);
    wait_cmd(n);
    chk("retry1_delay", n, 21);
    chk("retry1_tag", tlx.tlx_cmd_afutag, 16'hC001);
    chk("retry1_obj", tlx.tlx_cmd_obj, 68'hA5A5);
    backoff_limit = 4'd1;
    respond(16'hC001, 8'h0C, 4'b0010);
    wait_cmd(n);
    chk("retry2_delay", n, 41);
    respond(16'hC001, 8'h0C, 4'b0010);
    chk("retry3_ack", interrupt_ack, 4'b0010);
    chk("retry3_fail", int_fail, 4'b0010);
    drop(1);

    // pending then intrp_rdy
    retry_limit   = 8'd1;
    backoff_limit = 4'd0;
    raise_and_cmd(0, 64'hCAFE_F00D);
    respond(16'hC000, 8'h0C, 4'b0100);
    chk("pend_no_ack", interrupt_ack, 4'h0);
    respond(16'hC000, 8'h1A, 4'b0000);
    chk("pend_rdy_no_cmd_yet", tlx.tlx_cmd_valid, 1'b0);
    tick();
    chk("pend_reissue_valid", tlx.tlx_cmd_valid, 1'b1);
    chk("pend_reissue_obj", tlx.tlx_cmd_obj, 68'hCAFE_F00D);
    chk("pend_reissue_tag", tlx.tlx_cmd_afutag, 16'hC000);
    respond(16'hC000, 8'h0C, 4'b0010);
    chk("pend_retry_count_kept", interrupt_ack, 4'h0);
    wait_cmd(n);
    chk("pend_backoff_delay", n, 21);
    respond(16'hC000, 8'h0C, 4'b0100);
    respond(16'hC000, 8'h1A, 4'b0010);
    chk("pend_rdy_retry_ack", interrupt_ack, 4'b0001);
    chk("pend_rdy_retry_fail", int_fail, 4'b0001);
    drop(0);

    // stray responses
    respond(16'hC003, 8'h0C, 4'b0000);
    chk("stray_idle_pulse", rsp_stray, 1'b1);
    chk("stray_idle_no_ack", interrupt_ack, 4'h0);
    chk("stray_idle_no_cmd", tlx.tlx_cmd_valid, 1'b0);
    tick();
    chk("stray_one_cycle", rsp_stray, 1'b0);
    respond(16'h4001, 8'h0C, 4'b0000);
    chk("stray_prefix_pulse", rsp_stray, 1'b1);
    chk("stray_prefix_no_ack", interrupt_ack, 4'h0);

    // enable low holds requests and the pointer
    interrupt_enable            = 1'b0;
    interrupt_src[64*0 +: 64]   = 64'hE0;
    interrupt_src[64*2 +: 64]   = 64'hE2;
    interrupt[0]                = 1'b1;
    interrupt[2]                = 1'b1;
    cnt = 0;
    repeat (6) begin
      tick();
      if (tlx.tlx_cmd_valid) cnt++;
    end
    chk("en_low_no_cmd", cnt, 0);
    interrupt_enable = 1'b1;
    tick();
    chk("en_high_first_valid", tlx.tlx_cmd_valid, 1'b1);
    chk("en_high_first_tag", tlx.tlx_cmd_afutag, 16'hC002);
    tick();
    chk("en_high_second_tag", tlx.tlx_cmd_afutag, 16'hC000);
    chk("en_high_second_obj", tlx.tlx_cmd_obj, 68'hE0);

    // reset while both channels wait for responses
    rst = 1'b1;
    #1;
    chk("midrst_valid", tlx.tlx_cmd_valid, 1'b0);
    chk("midrst_obj", tlx.tlx_cmd_obj, 68'h0);
    chk("midrst_tag", tlx.tlx_cmd_afutag, 16'h0);
    chk("midrst_ack", interrupt_ack, 4'h0);
    interrupt = '0;
    tick();
    rst = 1'b0;
    tick();
    respond(16'hC002, 8'h0C, 4'b0000);
    chk("postrst_stray", rsp_stray, 1'b1);
    chk("postrst_no_ack", interrupt_ack, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
